// File: rtl/ethpipe_rx_slot_ctrl.sv
// ---------------------------------------------------------------------------
// ethpipe_rx_slot_ctrl
//
// RX frame slot controller, pci_clk domain. The slot RAM written by the
// ethpipe GMII port is split into a ring of NSLOT = 2^SLOT_BITS slots of
// 2048 words each. This block:
//   - tells the port which slot to fill next (slot_wr_sel) and whether that
//     slot is free (slot_rx_empty),
//   - on every completed frame reads the frame-length word of the slot and
//     commits the slot to an in-order queue for the host/DMA side,
//   - frees the oldest slot when the host releases it.
//
// Ports
//   pci_clk           sole clock
//   sys_rst           synchronous active-high reset
//   slot_rx_complete  1-cycle pulse per received frame (already in pci_clk)
//   slot_rx_empty     high = slot_wr_sel slot is free for the port to fill
//   slot_wr_sel       slot index the port writes into
//   ram_rd_en         slot RAM read strobe
//   ram_rd_addr       slot RAM read address {slot, word}
//   ram_rd_q          slot RAM read data, valid 1 cycle after ram_rd_en
//   host_valid        at least one filled slot is waiting for the host
//   host_slot         oldest filled slot index
//   host_len          frame length (bytes) of host_slot
//   host_release      1-cycle pulse: host is done with host_slot
//   rx_frames         committed-frame counter (wraps)
//   err_count         protocol-error counter (saturates)
// ---------------------------------------------------------------------------
module ethpipe_rx_slot_ctrl #(
    parameter int          SLOT_BITS  = 2,
    parameter logic [10:0] LEN_OFFSET = 11'h4
) (
    input  logic                  pci_clk,
    input  logic                  sys_rst,
    // GMII port side
    input  logic                  slot_rx_complete,
    output logic                  slot_rx_empty,
    output logic [SLOT_BITS-1:0]  slot_wr_sel,
    // slot RAM read port
    output logic                  ram_rd_en,
    output logic [SLOT_BITS+10:0] ram_rd_addr,
    input  logic [31:0]           ram_rd_q,
    // host / DMA side
    output logic                  host_valid,
    output logic [SLOT_BITS-1:0]  host_slot,
    output logic [10:0]           host_len,
    input  logic                  host_release,
    // statistics
    output logic [31:0]           rx_frames,
    output logic [15:0]           err_count
);

    localparam int NSLOT = 1 << SLOT_BITS;
    localparam logic [SLOT_BITS:0] NSLOT_CNT = (SLOT_BITS + 1)'(NSLOT);

    // Length fetch sequencer: READ issues the RAM read, WAIT captures the
    // returned length word and commits the slot.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e               state_q,     state_d;
    logic                 pend_q,      pend_d;
    logic [SLOT_BITS-1:0] wr_ptr_q,    wr_ptr_d;
    logic [SLOT_BITS-1:0] rd_ptr_q,    rd_ptr_d;
    logic [SLOT_BITS:0]   count_q,     count_d;
    logic [31:0]          rx_frames_q, rx_frames_d;
    logic [15:0]          err_count_q, err_count_d;
    logic [10:0]          len_tbl_q [NSLOT];

    // -----------------------------------------------------------------------
    // Per-cycle events
    // -----------------------------------------------------------------------
    logic        full;
    logic        commit;
    logic        rel_ok;
    logic        err_cpl;
    logic        err_rel;
    logic [16:0] err_sum;

    // Only the low 11 bits of the length word are meaningful.
    logic ram_q_hi_unused;
    assign ram_q_hi_unused = ^ram_rd_q[31:11];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rx_frames_d = rx_frames_q;
        err_cpl     = 1'b0;
        err_rel     = 1'b0;

        full   = (count_q == NSLOT_CNT);
        commit = (state_q == ST_WAIT);
        rel_ok = host_release && (count_q != '0);

        // Releasing with nothing queued is a host protocol error.
        if (host_release && !rel_ok) begin
            err_rel = 1'b1;
        end

        // Commit and release may coincide: count then stays put while both
        // pointers move.
        count_d = count_q
                + (SLOT_BITS + 1)'(commit)
                - (SLOT_BITS + 1)'(rel_ok);

        if (rel_ok) begin
            rd_ptr_d = rd_ptr_q + SLOT_BITS'(1);
        end

        if (commit) begin
            wr_ptr_d    = wr_ptr_q + SLOT_BITS'(1);
            rx_frames_d = rx_frames_q + 32'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!full && (pend_q || slot_rx_complete)) begin
                    state_d = ST_READ;
                    // The pending frame is served first; a new pulse in the
                    // same cycle takes its place in pend.
                    pend_d  = pend_q && slot_rx_complete;
                end else if (slot_rx_complete) begin
                    // Ring full: the port wrote into a slot it was told was
                    // busy, so there is nowhere to commit this frame.
                    err_cpl = 1'b1;
                end
            end

            ST_READ, ST_WAIT: begin
                // One frame can be remembered while a fetch is in flight;
                // a second one is lost.
                if (slot_rx_complete) begin
                    if (pend_q) begin
                        err_cpl = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end

                if (state_q == ST_READ) begin
                    state_d = ST_WAIT;
                end else if (pend_q && (count_d < NSLOT_CNT)) begin
                    // Chain straight into the next fetch so back-to-back
                    // frames cost two cycles each. wr_ptr has already
                    // advanced, so READ addresses the next slot.
                    state_d = ST_READ;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Up to two errors can land in one cycle; the counter saturates.
        err_sum     = {1'b0, err_count_q} + 17'(err_cpl) + 17'(err_rel);
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge pci_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_frames_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_frames_q <= rx_frames_d;
            err_count_q <= err_count_d;
        end
    end

    // Length table, one entry per slot, written when the slot commits.
    // NOTE: this small table is reset on purpose so host_len reads 0 after
    // reset; larger storage normally stays unreset and relies on valid bits.
    always_ff @(posedge pci_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                len_tbl_q[i] <= '0;
            end
        end else if (commit) begin
            len_tbl_q[wr_ptr_q] <= ram_rd_q[10:0];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The incoming pulse itself clears slot_rx_empty so the port never sees
    // the just-filled slot as free, even for the cycle of the pulse.
    assign slot_rx_empty = (state_q == ST_IDLE) && !pend_q
                        && !slot_rx_complete && (count_q < NSLOT_CNT);
    assign slot_wr_sel   = wr_ptr_q;

    assign ram_rd_en   = (state_q == ST_READ);
    assign ram_rd_addr = ram_rd_en ? {wr_ptr_q, LEN_OFFSET} : '0;

    assign host_valid = (count_q != '0);
    assign host_slot  = rd_ptr_q;
    assign host_len   = len_tbl_q[rd_ptr_q];

    assign rx_frames = rx_frames_q;
    assign err_count = err_count_q;

endmodule

// File: doc/ethpipe_rx_slot_ctrl.md
Name: ethpipe_rx_slot_ctrl

Overview:
- PCI-clock-domain controller for the RX frame slot RAM filled by the ethpipe GMII port.
- Organises the RAM as a ring of 2^SLOT_BITS slots of 2048 words each.
- Tells the port which slot to fill and whether it is free, via slot_rx_empty and slot_wr_sel.
- On each completed frame, fetches the frame-length word from the slot and queues the slot to the host/DMA side in arrival order. Frees the slot when the host releases it.

Parameters:
SLOT_BITS, 2, log2 of slot count (NSLOT = 2^SLOT_BITS, legal 1..4)
LEN_OFFSET, 11'h4, word offset of the frame-length word inside a slot

Ports:
pci_clk  in  1  sole clock (125 MHz)
sys_rst  in  1  synchronous active-high reset
slot_rx_complete  in  1  one-cycle pulse per received frame, already synchronised to pci_clk
slot_rx_empty  out  1  high = slot_wr_sel slot is free for the port to fill
slot_wr_sel  out  SLOT_BITS  slot index the port writes (upper RAM address bits)
ram_rd_en  out  1  slot RAM read strobe
ram_rd_addr  out  SLOT_BITS+11  slot RAM read address {slot, word}
ram_rd_q  in  32  slot RAM read data, valid exactly 1 cycle after ram_rd_en
host_valid  out  1  a filled slot is available to the host
host_slot  out  SLOT_BITS  oldest filled slot index
host_len  out  11  frame length of host_slot (bytes, from length word)
host_release  in  1  one-cycle pulse: host finished with host_slot
rx_frames  out  32  committed-frame counter
err_count  out  16  protocol-error counter

Behaviour:
- Reset (sys_rst high at a pci_clk edge): wr_ptr = 0, rd_ptr = 0, count = 0, state = IDLE, pend = 0.
- Reset values of outputs: slot_wr_sel = 0, ram_rd_en = 0, ram_rd_addr = 0, rx_frames = 0, err_count = 0, host_valid = 0, host_slot = 0, host_len = 0, slot_rx_empty = 1 from the first cycle after reset.
- Reset mid-fetch abandons the fetch; any RAM data arriving afterwards is ignored.
- Fetch FSM states: IDLE, READ, WAIT.
  - IDLE -> READ when slot_rx_complete = 1 or pend = 1. Clear pend if it was used.
  - READ (one cycle): ram_rd_en = 1, ram_rd_addr = {wr_ptr, LEN_OFFSET}. Go to WAIT.
  - WAIT (one cycle): capture ram_rd_q[10:0] into len_tbl[wr_ptr]; wr_ptr <= wr_ptr + 1 (wraps modulo NSLOT); count <= count + 1; rx_frames <= rx_frames + 1 (wraps). Go to IDLE.
- Latency: complete sampled in cycle T -> ram_rd_en in T+1 -> commit at the end of T+2 -> host_valid = 1 in T+3 (if the queue was empty).
- slot_rx_empty is combinational: (state == IDLE) && !pend && !slot_rx_complete && (count < NSLOT).
  - It drops in the same cycle as the complete pulse.
  - It stays low until the commit finishes and a free slot exists.
- slot_wr_sel = wr_ptr.
- Complete pulse while state != IDLE:
  - if pend = 0, set pend = 1;
  - if pend = 1, drop the pulse and err_count++ (saturating at 16'hFFFF).
- Complete pulse while count == NSLOT and state == IDLE: drop it and err_count++. No fetch is started.
- Host side:
  - host_valid = (count != 0); host_slot = rd_ptr; host_len = len_tbl[rd_ptr].
  - host_release with host_valid = 1: rd_ptr++ (wraps), count--.
  - host_release with host_valid = 0: ignored, err_count++.
- Commit and release in the same cycle: count unchanged, both pointers advance.
- A release that makes count < NSLOT raises slot_rx_empty in the next cycle (if IDLE and no pend).
- count is SLOT_BITS+1 bits wide and never exceeds NSLOT.

Test Plan:
- Single frame: reset, pulse complete, RAM returns 32'h0000_0040 at {0,4} -> ram_rd_en in T+1 with addr 0x004; host_valid = 1 in T+3 with host_slot = 0 and host_len = 64; slot_wr_sel = 1; rx_frames = 1; slot_rx_empty low T..T+2 and high from T+3.
- Ring fill (SLOT_BITS = 2): 4 frames with lengths 60, 100, 1514, 61 and no release -> count = 4, slot_rx_empty stays 0. A 5th pulse -> err_count = 1, no RAM read.
- Drain and wrap: after the fill, release 4 times -> host_len sequence 60, 100, 1514, 61; host_valid = 0 afterwards. A further frame lands in slot 0 (slot_wr_sel wrapped 3 -> 0) with rd_ptr = 0.
- Back-to-back: a second complete pulse arrives during READ -> pend set, second fetch follows directly (ram_rd_en at T+1 and T+3), rx_frames = 2, err_count = 0. A third pulse during the first fetch -> err_count = 1.
- Simultaneous commit and release with count = 2 -> count stays 2, host_slot advances by one. A release with the queue empty -> err_count increments, pointers unchanged.
- Reset asserted during WAIT -> all outputs return to reset values next cycle, slot_rx_empty = 1, rx_frames = 0.
